inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
Requester side of the instruction-memory interface. Holds the PC, drives a word address to the combinational instruction memory, and captures the returned word into an IF/ID output register. The output register uses a valid/ready handshake to decode. Branch/jump redirects from EX flush the output register, and misaligned or out-of-range fetch targets raise a sticky fault.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, byte-address width
MEM_SIZE, 512, instruction memory depth in words; valid byte range is 0 .. MEM_SIZE*4-1
RESET_PC, 0, PC loaded on reset; word-aligned and in range

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  ADDR_WIDTH  byte address to instruction memory (= pc)
imem_instr  input  DATA_WIDTH  instruction word; combinational, valid same cycle
redirect_valid  input  1  taken branch/jump from EX
redirect_pc  input  ADDR_WIDTH  redirect target byte address
out_valid  output  1  output register holds an instruction
out_ready  input  1  decode accepts this cycle
out_instr  output  DATA_WIDTH  fetched instruction
out_pc  output  ADDR_WIDTH  byte address of out_instr
fetch_count  output  32  instructions captured into the output register
fault  output  1  sticky fetch fault
fault_pc  output  ADDR_WIDTH  offending address

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset is rst_n, asynchronous assert, active-low.
- Reset values:
  - pc = RESET_PC; state = BOOT.
  - out_valid = 0; out_instr = 0x00000013 (NOP); out_pc = 0.
  - fetch_count = 0; fault = 0; fault_pc = 0.
- imem_addr = pc at all times (combinational from the register).
- States:
  - BOOT: one cycle, no capture, then RUN.
  - RUN: normal fetch.
  - FAULT: terminal until reset.
- Capture condition in RUN: (!out_valid || out_ready), no redirect, pc < MEM_SIZE*4.
  - On capture: out_instr <= imem_instr, out_pc <= pc, out_valid <= 1, pc <= pc+4, fetch_count += 1 (wraps mod 2^32).
- Consume without capture: if out_valid && out_ready and the capture condition fails, out_valid <= 0.
- Stall: out_valid && !out_ready, so out_instr, out_pc and pc hold stable. out_instr/out_pc must not change while out_valid=1 and out_ready=0.
- Redirect in RUN has priority over capture:
  - out_valid <= 0; any held instruction is dropped. A handshake completing in the same cycle still counts as taken by decode.
  - If redirect_pc[1:0] == 0 and redirect_pc < MEM_SIZE*4: pc <= redirect_pc.
  - Otherwise: state <= FAULT, fault <= 1, fault_pc <= redirect_pc, pc unchanged.
- Sequential overrun: in RUN with pc >= MEM_SIZE*4 and no redirect, go to FAULT with fault_pc = pc. No capture that cycle; out_valid follows the consume rule.
- Arithmetic: pc+4 is ADDR_WIDTH bits and wraps naturally. The range check precedes any use of a wrapped value.
- FAULT state:
  - out_valid <= 0 next cycle; redirects ignored; pc, fetch_count, fault_pc frozen.
  - Exit only via rst_n.
- BOOT: redirect_valid is ignored.
- Reset mid-stall or mid-fault: all state returns to reset values asynchronously. The first capture occurs on the second rising edge after deassertion.
- Latency: the instruction at pc appears on out_instr one cycle after capture. Sustained throughput is 1 instruction/cycle while out_ready=1.

Decomposition:
- Shared package rv_fetch_pkg:
  - state enum {BOOT, RUN, FAULT}.
  - INSTR_BYTES = 4; NOP_INSTR = 32'h00000013.
  - Helper function addr_in_range(addr, MEM_SIZE).
- One natural sub-module: fetch_out_reg, the IF/ID valid/ready holding register with a flush input. The PC/FSM stays in the top.

Test Plan:
1. Reset release, out_ready=1, memory words 0x11,0x22,0x33 at addrs 0,4,8 -> out_valid first high after 2nd edge. out_pc 0,4,8 on consecutive cycles with matching out_instr; fetch_count=3.
2. out_ready low for 3 cycles while out_pc=4 -> out_instr/out_pc held at word@4, imem_addr stays 8, fetch_count constant. Release -> out_pc=8 next cycle.
3. redirect_valid with redirect_pc=0x40 while out_valid=1, out_ready=0 -> out_valid=0 next cycle, then out_pc=0x40. The dropped instruction is never presented.
4. redirect_pc=0x42 -> fault=1, fault_pc=0x42, out_valid=0, no further captures. A subsequent aligned redirect is ignored.
5. MEM_SIZE=4, run from 0 -> captures at 0,4,8,12, then fault=1 with fault_pc=0x10; fetch_count=4.
6. Assert rst_n low during FAULT and during a stall -> all outputs at reset values immediately, without waiting for a clock edge. Normal fetch resumes from RESET_PC.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// ----------------------------------------------------------------------------
// rv_fetch_pkg : shared types, constants and helpers for the fetch unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv_fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   // Evaluated at 64 bits so the bound never wraps for any legal ADDR_WIDTH.
   function automatic logic addr_in_range(input logic [63:0] addr,
                                          input int unsigned mem_size);
      return addr < (64'(mem_size) * 64'(INSTR_BYTES));
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_out_reg.sv
// ----------------------------------------------------------------------------
// fetch_out_reg : IF/ID valid/ready holding register with flush
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_out_reg
   import rv_fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] pc_q,    pc_d;

   // Payload only moves on load, so a stalled or flushed entry stays put.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= DATA_WIDTH'(NOP_INSTR);
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// inst_fetch_unit : PC/FSM, imem request and fault tracking around the IF/ID reg
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module inst_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           MEM_SIZE   = 512,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_instr,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [31:0]           fetch_count,
   output logic                  fault,
   output logic [ADDR_WIDTH-1:0] fault_pc
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]           count_q, count_d;
   logic                  fault_q, fault_d;
   logic [ADDR_WIDTH-1:0] fault_pc_q, fault_pc_d;
   logic                  capture;
   logic                  flush;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      count_d    = count_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      capture    = 1'b0;
      flush      = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            // Redirect outranks capture; the range check precedes pc+4 so a wrap is never fetched.
            if (redirect_valid) begin
               flush = 1'b1;
               if ((redirect_pc[1:0] == 2'b00) &&
                   addr_in_range(64'(redirect_pc), MEM_SIZE)) begin
                  pc_d = redirect_pc;
               end else begin
                  state_d    = FAULT;
                  fault_d    = 1'b1;
                  fault_pc_d = redirect_pc;
               end
            end else if (!addr_in_range(64'(pc_q), MEM_SIZE)) begin
               state_d    = FAULT;
               fault_d    = 1'b1;
               fault_pc_d = pc_q;
            end else if (!out_valid || out_ready) begin
               capture = 1'b1;
               pc_d    = pc_q + ADDR_WIDTH'(INSTR_BYTES);
               count_d = count_q + 32'd1;
            end
         end
         FAULT:   flush = 1'b1;
         default: state_d = FAULT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         count_q    <= '0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   fetch_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (capture),
      .flush_i (flush),
      .instr_i (imem_instr),
      .pc_i    (pc_q),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .instr_o (out_instr),
      .pc_o    (out_pc)
   );

   assign imem_addr   = pc_q;
   assign fetch_count = count_q;
   assign fault       = fault_q;
   assign fault_pc    = fault_pc_q;

endmodule

`default_nettype wire
